decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
- Decode/issue controller between fetch and execute in the 3-stage core.
- Holds one instruction in a pipeline slot and classifies its immediate format (imm_sel) for the immediate generator.
- Extracts register indices and flags illegal opcodes.
- Sequences issue to execute with valid/ready handshakes, a load-use stall counter, and branch/jump flush.

Parameters:
- XLEN, 32, width of instruction and PC.
- LOAD_USE_STALL, 1, cycles a dependent instruction is held after a load issues (1..7).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  XLEN  fetched instruction.
- if_pc  in  XLEN  PC of if_instr.
- if_ready  out  1  slot accepts if_instr this cycle.
- flush  in  1  execute redirect (taken branch/jump); kills the slot.
- id_valid  out  1  slot instruction issuable to execute.
- ex_ready  in  1  execute accepts issue.
- id_instr  out  XLEN  slot instruction.
- id_pc  out  XLEN  slot PC.
- id_imm_sel  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- id_rs1, id_rs2, id_rd  out  5  instr[19:15], [24:20], [11:7].
- id_illegal  out  1  opcode not recognised.
- id_stall  out  1  slot held by load-use hazard.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: slot_valid=0, id_instr=0x00000013 (NOP), id_pc=0, stall_cnt=0, ld_rd=0. Hence id_valid=0, id_stall=0, id_imm_sel=1, id_illegal=0, if_ready=1.
- Slot decode is combinational from registered id_instr, by opcode [6:0]:
  - 0000011, 0010011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011, 1110011 -> none.
  - Any other opcode -> none, with id_illegal=1 while slot_valid.
- Source usage:
  - uses_rs1 for I, S, B and 0110011.
  - uses_rs2 for S, B and 0110011.
- Hazard: hazard = slot_valid & stall_cnt!=0 & ((uses_rs1 & rs1==ld_rd) | (uses_rs2 & rs2==ld_rd)).
- Issue side:
  - id_valid = slot_valid & !hazard & !flush.
  - id_stall = hazard.
  - issue = id_valid & ex_ready.
- Fetch side:
  - if_ready = !flush & (!slot_valid | issue).
  - accept = if_valid & if_ready.
- Slot update, in priority order:
  1. flush -> slot_valid=0; id_instr, id_pc unchanged.
  2. accept -> capture if_instr and if_pc, slot_valid=1.
  3. issue -> slot_valid=0.
  4. Otherwise hold.
- Throughput: accept and issue in the same cycle give back-to-back, 1 instruction/cycle. Latency fetch -> issue is 1 cycle minimum.
- Load-use counter:
  - When issue and the slot opcode is 0000011 and rd!=0: stall_cnt <= LOAD_USE_STALL, ld_rd <= rd.
  - Else if stall_cnt!=0: stall_cnt decrements by 1 every cycle, independent of ex_ready.
  - Counter saturates at 0.
  - rd==0 loads never arm the counter.
- Flush does not clear stall_cnt, because the load already in execute still writes back.
- Load followed by load: the second load may itself be stalled. On its issue it re-arms the counter.
- Holding: while !ex_ready or hazard, the slot holds stable (instr, pc, decode outputs constant) and if_ready=0.
- Reset mid-operation: reset overrides everything the next edge and discards the slot and counter.

Test Plan:
- Reset, then if_valid=1 with instr 0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle id_valid=1, id_imm_sel=1, id_rd=1. Continuous stream issues 1/cycle with if_ready=1 throughout.
- Backpressure: load sw 0x0020A023 into the slot, hold ex_ready=0 for 3 cycles -> id_valid=1, id_imm_sel=2, if_ready=0, outputs stable. ex_ready=1 -> issue and accept the same cycle.
- Load-use: lw x5,0(x1) (0x0000A283) issues at cycle t, then add x6,x5,x2 -> at t+1 id_valid=0, id_stall=1; at t+2 id_valid=1. With LOAD_USE_STALL=3 the add issues at t+4.
- Independent after load: lw x5 then add x6,x7,x8 -> no stall, issues at t+1.
- Load to x0: lw x0 then add using x0 -> no stall.
- Flush with slot full and if_valid=1 -> next cycle id_valid=0, and if_ready=0 during the flush cycle. Opcode 0x0000007F -> id_illegal=1, id_imm_sel=0. Reset asserted during a stall -> id_valid=0, id_stall=0, if_ready=1.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// Decode/issue slot between fetch and execute: holds one instruction, classifies
// its immediate format, tracks load-use hazards and handles redirect flushes.
module decode_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  output logic            id_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [2:0]      id_imm_sel,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic            id_illegal,
  output logic            id_stall
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALL);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  logic       slot_valid;
  logic [2:0] stall_cnt;
  logic [4:0] ld_rd;
  logic [6:0] opcode;
  logic       known;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;
  logic       issue;
  logic       accept;
  logic       arm;

  assign opcode = id_instr[6:0];
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];
  assign id_rd  = id_instr[11:7];

  always_comb begin
    id_imm_sel = IMM_NONE;
    known      = 1'b1;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        id_imm_sel = IMM_I;
        uses_rs1   = 1'b1;
      end
      OP_STORE: begin
        id_imm_sel = IMM_S;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_BRANCH: begin
        id_imm_sel = IMM_B;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_LUI, OP_AUIPC: id_imm_sel = IMM_U;
      OP_JAL:           id_imm_sel = IMM_J;
      OP_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_SYS:  known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  assign id_illegal = slot_valid & ~known;

  assign hazard = slot_valid & (stall_cnt != 3'd0) &
                  ((uses_rs1 & (id_rs1 == ld_rd)) | (uses_rs2 & (id_rs2 == ld_rd)));
  assign id_stall = hazard;
  assign id_valid = slot_valid & ~hazard & ~flush;
  assign issue    = id_valid & ex_ready;
  assign if_ready = ~flush & (~slot_valid | issue);
  assign accept   = if_valid & if_ready;
  assign arm      = issue & (opcode == OP_LOAD) & (id_rd != 5'd0);

  // The counter survives flush: the load already in execute still writes back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc      <= '0;
      stall_cnt  <= 3'd0;
      ld_rd      <= 5'd0;
    end else begin
      if (flush) begin
        slot_valid <= 1'b0;
      end else if (accept) begin
        slot_valid <= 1'b1;
        id_instr   <= if_instr;
        id_pc      <= if_pc;
      end else if (issue) begin
        slot_valid <= 1'b0;
      end

      if (arm) begin
        stall_cnt <= STALL_INIT;
        ld_rd     <= id_rd;
      end else if (stall_cnt != 3'd0) begin
        stall_cnt <= stall_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: two instances (load-use shadow 1 and 3) driven in
// lockstep, checked against a cycle-stamped reference model.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;

  logic [1:0]  if_ready, id_valid, id_illegal, id_stall;
  logic [31:0] id_instr [2];
  logic [31:0] id_pc    [2];
  logic [2:0]  id_imm_sel [2];
  logic [4:0]  id_rs1 [2];
  logic [4:0]  id_rs2 [2];
  logic [4:0]  id_rd  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_issue_ctrl #(.XLEN(32), .LOAD_USE_STALL((g == 0) ? 1 : 3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_valid  (if_valid),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .if_ready  (if_ready[g]),
      .flush     (flush),
      .id_valid  (id_valid[g]),
      .ex_ready  (ex_ready),
      .id_instr  (id_instr[g]),
      .id_pc     (id_pc[g]),
      .id_imm_sel(id_imm_sel[g]),
      .id_rs1    (id_rs1[g]),
      .id_rs2    (id_rs2[g]),
      .id_rd     (id_rd[g]),
      .id_illegal(id_illegal[g]),
      .id_stall  (id_stall[g])
    );
  end

  // Reference model: slot contents plus the cycle at which the last arming load issued.
  int          lus [2] = '{1, 3};
  bit          m_valid [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pc    [2];
  int          m_ld_cyc [2];
  logic [4:0]  m_ld_rd  [2];
  int          cyc = 0;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic logic [2:0] m_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return 3'd1;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6f:               return 3'd5;
      default:             return 3'd0;
    endcase
  endfunction

  function automatic bit m_known(input logic [31:0] ins);
    return (m_fmt(ins) != 3'd0) || ins[6:0] == 7'h33 || ins[6:0] == 7'h73;
  endfunction

  function automatic bit m_src1(input logic [31:0] ins);
    logic [2:0] f;
    f = m_fmt(ins);
    return (f == 3'd1 || f == 3'd2 || f == 3'd3 || ins[6:0] == 7'h33);
  endfunction

  function automatic bit m_src2(input logic [31:0] ins);
    logic [2:0] f;
    f = m_fmt(ins);
    return (f == 3'd2 || f == 3'd3 || ins[6:0] == 7'h33);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k]  = 1'b0;
      m_instr[k]  = 32'h0000_0013;
      m_pc[k]     = 32'h0;
      m_ld_cyc[k] = -100;
      m_ld_rd[k]  = 5'd0;
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                       input logic er, input logic rn);
    if_valid = iv;
    if_instr = ins;
    if_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 32'd4;
    flush    = fl;
    ex_ready = er;
    rst_n    = rn;
    #1;
  endtask

  // Compare every output of both instances to the model, then advance one clock.
  task automatic tick();
    bit haz, ev, iss [2], acc [2], ifr;
    logic [31:0] ins;
    for (int k = 0; k < 2; k++) begin
      ins = m_instr[k];
      haz = m_valid[k] && (cyc > m_ld_cyc[k]) && (cyc - m_ld_cyc[k] <= lus[k]) &&
            ((m_src1(ins) && ins[19:15] == m_ld_rd[k]) ||
             (m_src2(ins) && ins[24:20] == m_ld_rd[k]));
      ev  = m_valid[k] && !haz && !flush;
      ifr = !flush && (!m_valid[k] || (ev && ex_ready));
      iss[k] = ev && ex_ready;
      acc[k] = if_valid && ifr;
      chk($sformatf("id_valid[%0d]@%0d", k, cyc), 64'(id_valid[k]), 64'(ev));
      chk($sformatf("if_ready[%0d]@%0d", k, cyc), 64'(if_ready[k]), 64'(ifr));
      chk($sformatf("id_stall[%0d]@%0d", k, cyc), 64'(id_stall[k]), 64'(haz));
      chk($sformatf("id_illegal[%0d]@%0d", k, cyc), 64'(id_illegal[k]),
          64'(m_valid[k] && !m_known(ins)));
      chk($sformatf("id_imm_sel[%0d]@%0d", k, cyc), 64'(id_imm_sel[k]), 64'(m_fmt(ins)));
      chk($sformatf("id_instr_pc[%0d]@%0d", k, cyc), {id_instr[k], id_pc[k]}, {ins, m_pc[k]});
      chk($sformatf("id_regs[%0d]@%0d", k, cyc), 64'({id_rs1[k], id_rs2[k], id_rd[k]}),
          64'({ins[19:15], ins[24:20], ins[11:7]}));
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (iss[k] && m_instr[k][6:0] == 7'h03 && m_instr[k][11:7] != 5'd0) begin
          m_ld_cyc[k] = cyc;
          m_ld_rd[k]  = m_instr[k][11:7];
        end
        if (flush)        m_valid[k] = 1'b0;
        else if (acc[k]) begin
          m_valid[k] = 1'b1;
          m_instr[k] = if_instr;
          m_pc[k]    = if_pc;
        end else if (iss[k]) m_valid[k] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6f, 7'h33, 7'h73, 7'h7f, 7'h0b};
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_DEP = 32'h00228333;
  localparam logic [31:0] ADD_IND = 32'h00838333;
  localparam logic [31:0] ADD_X0  = 32'h00200333;

  initial begin
    if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    drive(0, 0, 0, 1, 0); tick();

    drive(0, 0, 0, 1, 1);
    chk("reset_valid", 64'(id_valid), 64'd0);
    chk("reset_if_ready", 64'(if_ready), 64'd3);
    chk("reset_imm_sel", 64'(id_imm_sel[0]), 64'd1);
    chk("reset_stall_illegal", 64'({id_stall, id_illegal}), 64'd0);
    chk("reset_instr", 64'(id_instr[0]), 64'h13);
    tick();

    // Back-to-back stream
    drive(1, 32'h00500093, 0, 1, 1); tick();
    drive(1, 32'h00A00113, 0, 1, 1);
    chk("addi_valid", 64'(id_valid[0]), 64'd1);
    chk("addi_imm_rd", 64'({id_imm_sel[0], id_rd[0]}), 64'({3'd1, 5'd1}));
    chk("stream_if_ready", 64'(if_ready[0]), 64'd1);
    tick();
    drive(1, 32'h00F00193, 0, 1, 1);
    chk("stream_valid2", 64'({id_valid[0], if_ready[0]}), 64'b11);
    tick();
    drive(0, 0, 0, 1, 1); tick(); tick();

    // Backpressure on a store
    drive(1, 32'h0020A023, 0, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00500093, 0, 0, 1);
      chk("bp_hold", 64'({id_valid[0], id_imm_sel[0], if_ready[0]}), 64'({1'b1, 3'd2, 1'b0}));
      tick();
    end
    drive(1, 32'h00500093, 0, 1, 1);
    chk("bp_release_if_ready", 64'(if_ready[0]), 64'd1);
    tick();
    drive(0, 0, 0, 1, 1); tick(); tick();

    // Load-use: shadow 1 issues at t+2, shadow 3 at t+4
    drive(1, LW_X5, 0, 1, 1); tick();
    drive(1, ADD_DEP, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1);
    chk("lu_t1", 64'({id_valid, id_stall}), 64'b00_11);
    tick();
    chk("lu_t2", 64'(id_valid), 64'b01);
    tick();
    chk("lu_t3_shadow3", 64'(id_valid[1]), 64'd0);
    tick();
    chk("lu_t4_shadow3", 64'(id_valid[1]), 64'd1);
    tick(); tick(); tick();

    // Independent instruction after a load
    drive(1, LW_X5, 0, 1, 1); tick();
    drive(1, ADD_IND, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1);
    chk("indep_no_stall", 64'({id_valid, id_stall}), 64'b11_00);
    tick(); tick(); tick(); tick(); tick();

    // Load to x0 never arms
    drive(1, LW_X0, 0, 1, 1); tick();
    drive(1, ADD_X0, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1);
    chk("x0_no_stall", 64'({id_valid, id_stall}), 64'b11_00);
    tick(); tick();

    // Flush with slot full and fetch valid
    drive(1, 32'h00500093, 0, 0, 1); tick();
    drive(1, 32'h00A00113, 1, 0, 1);
    chk("flush_cycle", 64'({if_ready[0], id_valid[0]}), 64'b00);
    tick();
    drive(0, 0, 0, 1, 1);
    chk("after_flush", 64'(id_valid[0]), 64'd0);
    tick();

    // Illegal opcode
    drive(1, 32'h0000007F, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1);
    chk("illegal", 64'({id_illegal[0], id_imm_sel[0], id_valid[0]}), 64'({1'b1, 3'd0, 1'b1}));
    tick();
    drive(0, 0, 0, 1, 1); tick();

    // Reset during a stall
    drive(1, LW_X5, 0, 1, 1); tick();
    drive(1, ADD_DEP, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1);
    chk("pre_reset_stall", 64'(id_stall[1]), 64'd1);
    tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 1, 1);
    chk("reset_in_stall", 64'({id_valid, id_stall, if_ready}), 64'b00_00_11);
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
